// File: rtl/apb_uart_pkg.sv
// Shared definitions for the UART APB control/status block: FSM encoding,
// register indices and STATUS bit positions.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } apb_state_e;

  localparam int REG_BAUD   = 0;
  localparam int REG_CTRL   = 1;
  localparam int REG_TXDATA = 2;
  localparam int REG_RXDATA = 3;
  localparam int REG_STATUS = 4;
  localparam int REG_IER    = 5;

  localparam int STAT_TX_RDY = 0;
  localparam int STAT_RX_RDY = 1;
  localparam int STAT_TXOVF  = 2;
  localparam int STAT_RXUND  = 3;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 slave protocol FSM: wait-state counter, pready generation, commit
// strobe and the address/direction captured in the setup phase.
module apb_slave_fsm
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              pready,
  output logic              commit,
  output logic              setup_go,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              acc_wr
);

  apb_state_e state, state_nxt;
  logic [3:0] wait_cnt;

  // A setup phase seen from IDLE is handled in that same cycle, so a
  // zero-wait transfer still completes in two cycles.
  always_comb begin
    state_nxt = state;
    setup_go  = 1'b0;
    pready    = (state == S_ACCESS) && (wait_cnt == '0) && psel && penable;
    case (state)
      S_IDLE: begin
        if (psel && !penable) begin
          setup_go  = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_SETUP: begin
        if (psel) begin
          setup_go  = 1'b1;
          state_nxt = S_ACCESS;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!psel)       state_nxt = S_IDLE;
        else if (pready) state_nxt = S_SETUP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign commit = pready;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      acc_addr <= '0;
      acc_wr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (setup_go) begin
        wait_cnt <= 4'(WAIT_STATES);
        acc_addr <= paddr;
        acc_wr   <= pwrite;
      end else if (state == S_ACCESS && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/apb_uart_csr.sv
// UART APB3 control/status registers with TX/RX side-effect strobes and sticky
// error flags. Optional IER register and irq output under APB_UART_CSR_IRQ_EN.
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 3,
  parameter int          WAIT_STATES = 0,
  parameter int unsigned BAUD_RST    = 0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] baud_val,
  output logic [DATA_W-1:0] ctrl,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_rdy,
`ifdef APB_UART_CSR_IRQ_EN
  output logic              irq,
`endif
  output logic              rx_rd
);

  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(REG_BAUD);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(REG_TXDATA);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(REG_RXDATA);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);
  localparam logic [ADDR_W-1:0] A_IER    = ADDR_W'(REG_IER);

  logic              commit, setup_go, acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] prdata_q, rd_setup, status_v;
  logic              txovf, rxund;
  logic              wr_tx, rd_rx, wr_st, mapped;
`ifdef APB_UART_CSR_IRQ_EN
  logic [2:0]        ier_q;
`endif

  apb_slave_fsm #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES)) u_fsm (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pready   (pready),
    .commit   (commit),
    .setup_go (setup_go),
    .acc_addr (acc_addr),
    .acc_wr   (acc_wr)
  );

  always_comb begin
    status_v              = '0;
    status_v[STAT_TX_RDY] = tx_rdy;
    status_v[STAT_RX_RDY] = rx_rdy;
    status_v[STAT_TXOVF]  = txovf;
    status_v[STAT_RXUND]  = rxund;
  end

  always_comb begin
    rd_setup = '0;
    case (paddr)
      A_BAUD:   rd_setup = baud_val;
      A_CTRL:   rd_setup = ctrl;
      A_STATUS: rd_setup = status_v;
`ifdef APB_UART_CSR_IRQ_EN
      A_IER:    rd_setup = DATA_W'(ier_q);
`endif
      default:  rd_setup = '0;
    endcase
  end

`ifdef APB_UART_CSR_IRQ_EN
  assign mapped = (acc_addr <= A_IER);
`else
  assign mapped = (acc_addr <= A_STATUS);
`endif

  // RXDATA bypasses the setup-time snapshot so the returned byte matches the
  // rx_rdy value that decides the pop / underflow at the commit edge.
  assign prdata  = (acc_addr == A_RXDATA) ? (rx_rdy ? rx_data : '0) : prdata_q;
  assign pslverr = pready & (~mapped | (acc_wr & (acc_addr == A_RXDATA)));

  assign wr_tx = commit &  acc_wr & (acc_addr == A_TXDATA);
  assign rd_rx = commit & ~acc_wr & (acc_addr == A_RXDATA);
  assign wr_st = commit &  acc_wr & (acc_addr == A_STATUS);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      prdata_q <= '0;
      baud_val <= DATA_W'(BAUD_RST);
      ctrl     <= '0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
      rx_rd    <= 1'b0;
      txovf    <= 1'b0;
      rxund    <= 1'b0;
    end else begin
      tx_wr <= wr_tx & tx_rdy;
      rx_rd <= rd_rx & rx_rdy;
      // A new setting event beats a write-1-to-clear on the same edge.
      txovf <= (wr_tx & ~tx_rdy) | (txovf & ~(wr_st & pwdata[STAT_TXOVF]));
      rxund <= (rd_rx & ~rx_rdy) | (rxund & ~(wr_st & pwdata[STAT_RXUND]));
      if (setup_go) prdata_q <= rd_setup;
      if (commit && acc_wr) begin
        case (acc_addr)
          A_BAUD:   baud_val <= pwdata;
          A_CTRL:   ctrl     <= pwdata;
          A_TXDATA: if (tx_rdy) tx_data <= pwdata;
          default:  ;
        endcase
      end
    end
  end

`ifdef APB_UART_CSR_IRQ_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ier_q <= '0;
      irq   <= 1'b0;
    end else begin
      if (commit && acc_wr && acc_addr == A_IER) ier_q <= pwdata[2:0];
      irq <= |(ier_q & {txovf | rxund, tx_rdy, rx_rdy});
    end
  end
`endif

endmodule

// File: tb/tb_apb_uart_csr.sv
// Bench for apb_uart_csr: three instances (0/2/3 wait states) on a shared bus
// with private selects; expected responses go through a scoreboard queue.
module tb_apb_uart_csr;

  localparam int         DW   = 8;
  localparam int         AW   = 3;
  localparam logic [7:0] BRST = 8'h10;

  logic          pclk = 1'b0, preset = 1'b1;
  logic          penable = 1'b0, pwrite = 1'b0, tx_rdy = 1'b0, rx_rdy = 1'b0;
  logic [2:0]    psel = '0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0, rx_data = '0;

  logic [DW-1:0] prdata [3];
  logic [DW-1:0] baud_val [3];
  logic [DW-1:0] ctrl [3];
  logic [DW-1:0] tx_data [3];
  logic          pready [3];
  logic          pslverr [3];
  logic          tx_wr [3];
  logic          rx_rd [3];

  int txw [3] = '{0, 0, 0};
  int rxr [3] = '{0, 0, 0};
  int dual = 0;
  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    logic       chk_rd;
    int         lat;
  } exp_t;
  exp_t sb [$];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_uart_csr #(
      .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(g == 0 ? 0 : g + 1), .BAUD_RST(BRST)
    ) u_dut (
      .pclk(pclk), .preset(preset), .psel(psel[g]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[g]),
      .pready(pready[g]), .pslverr(pslverr[g]), .baud_val(baud_val[g]),
      .ctrl(ctrl[g]), .tx_data(tx_data[g]), .tx_wr(tx_wr[g]), .tx_rdy(tx_rdy),
      .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rd(rx_rd[g])
    );
  end

  always @(negedge pclk) begin
    for (int d = 0; d < 3; d++) begin
      if (tx_wr[d]) txw[d]++;
      if (rx_rd[d]) rxr[d]++;
      if (tx_wr[d] && rx_rd[d]) dual++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One APB transfer on instance d; b2b keeps psel high into the next one.
  task automatic apb(input int d, input logic wr, input logic [AW-1:0] a,
                     input logic [7:0] wd, input logic [7:0] er, input logic ee,
                     input bit b2b, input string tag);
    exp_t e;
    int   cyc;
    e.rd = er; e.err = ee; e.chk_rd = !wr; e.lat = (d == 0) ? 2 : d + 3;
    sb.push_back(e);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1 penable = 1'b1;
    for (cyc = 2; cyc < 40; cyc++) begin
      @(negedge pclk);
      if (pready[d]) break;
      @(posedge pclk); #1;
    end
    e = sb.pop_front();
    chk({tag, ":lat"}, cyc, e.lat);
    chk({tag, ":err"}, pslverr[d], e.err);
    if (e.chk_rd) chk({tag, ":rd"}, prdata[d], e.rd);
    @(posedge pclk); #1 penable = 1'b0;
    if (!b2b) begin
      psel = '0;
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, r0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pready%0d", d), pready[d], 1'b0);
      chk($sformatf("rst_baud%0d", d), baud_val[d], BRST);
    end
    chk("rst_prdata", prdata[0], 8'h00);
    chk("rst_pslverr", pslverr[0], 1'b0);
    chk("rst_ctrl", ctrl[0], 8'h00);
    chk("rst_txdata", tx_data[0], 8'h00);
    @(posedge pclk); #1;

    // Reset lands mid-ACCESS on the 3-wait-state instance.
    psel = 3'b100; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h5A; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 preset = 1'b1;
    @(negedge pclk);
    chk("midrst_pready", pready[2], 1'b0);
    chk("midrst_baud", baud_val[2], BRST);
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1 preset = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("midrst_baud_after", baud_val[2], BRST);
    chk("midrst_no_txwr", txw[2], 0);
    @(posedge pclk); #1;
    apb(2, 1'b1, 3'd1, 8'h33, 8'h00, 1'b0, 1'b0, "ws3_wr_ctrl");
    apb(2, 1'b0, 3'd1, 8'h00, 8'h33, 1'b0, 1'b0, "ws3_rd_ctrl");

    // Zero-wait instance: register map and side effects.
    apb(0, 1'b1, 3'd0, 8'h1B, 8'h00, 1'b0, 1'b0, "wr_baud");
    apb(0, 1'b0, 3'd0, 8'h00, 8'h1B, 1'b0, 1'b0, "rd_baud");
    chk("baud_out", baud_val[0], 8'h1B);
    apb(0, 1'b1, 3'd1, 8'h5A, 8'h00, 1'b0, 1'b0, "wr_ctrl");
    chk("ctrl_out", ctrl[0], 8'h5A);

    tx_rdy = 1'b1; t0 = txw[0];
    apb(0, 1'b1, 3'd2, 8'hA5, 8'h00, 1'b0, 1'b0, "wr_tx_ok");
    chk("tx_data_a5", tx_data[0], 8'hA5);
    chk("tx_wr_once", txw[0] - t0, 1);
    tx_rdy = 1'b0;
    apb(0, 1'b1, 3'd2, 8'h3C, 8'h00, 1'b0, 1'b0, "wr_tx_ovf");
    chk("tx_data_kept", tx_data[0], 8'hA5);
    chk("tx_wr_none", txw[0] - t0, 1);
    apb(0, 1'b0, 3'd4, 8'h00, 8'h04, 1'b0, 1'b0, "st_txovf");
    apb(0, 1'b0, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, "rd_txdata");

    rx_rdy = 1'b1; rx_data = 8'h77; r0 = rxr[0];
    apb(0, 1'b0, 3'd3, 8'h00, 8'h77, 1'b0, 1'b0, "rd_rx_ok");
    chk("rx_rd_once", rxr[0] - r0, 1);
    rx_rdy = 1'b0;
    apb(0, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, "rd_rx_und");
    chk("rx_rd_none", rxr[0] - r0, 1);
    tx_rdy = 1'b1;
    apb(0, 1'b0, 3'd4, 8'h00, 8'h0D, 1'b0, 1'b0, "st_both");
    apb(0, 1'b1, 3'd4, 8'h08, 8'h00, 1'b0, 1'b0, "w1c_rxund");
    apb(0, 1'b0, 3'd4, 8'h00, 8'h05, 1'b0, 1'b0, "st_after_rx_clr");
    apb(0, 1'b1, 3'd4, 8'h04, 8'h00, 1'b0, 1'b0, "w1c_txovf");
    apb(0, 1'b0, 3'd4, 8'h00, 8'h01, 1'b0, 1'b0, "st_clear");

    // Error responses leave all state alone.
    apb(0, 1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 1'b0, "rd_unmapped7");
    apb(0, 1'b1, 3'd7, 8'hFF, 8'h00, 1'b1, 1'b0, "wr_unmapped7");
    apb(0, 1'b1, 3'd3, 8'hEE, 8'h00, 1'b1, 1'b0, "wr_rxdata");
    apb(0, 1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 1'b0, "rd_unmapped5");
    chk("err_baud_kept", baud_val[0], 8'h1B);
    chk("err_ctrl_kept", ctrl[0], 8'h5A);
    chk("err_no_rx_rd", rxr[0] - r0, 1);
    apb(0, 1'b0, 3'd4, 8'h00, 8'h01, 1'b0, 1'b0, "st_after_err");

    // Back-to-back on the 2-wait-state instance.
    apb(1, 1'b1, 3'd0, 8'h11, 8'h00, 1'b0, 1'b1, "b2b_baud1");
    apb(1, 1'b1, 3'd0, 8'h22, 8'h00, 1'b0, 1'b1, "b2b_baud2");
    apb(1, 1'b1, 3'd1, 8'h3C, 8'h00, 1'b0, 1'b0, "b2b_ctrl");
    chk("b2b_baud_final", baud_val[1], 8'h22);
    chk("b2b_ctrl_final", ctrl[1], 8'h3C);

    chk("no_dual_strobe", dual, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
